// File: rtl/sprite_scanner_if.sv
// rtl/sprite_scanner_if.sv - pixel-write stream between sprite_scanner and the buffer writer
interface sprite_scanner_if #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int COLOR_W = 3
);
  logic               out_valid;
  logic               out_ready;
  logic [X_W-1:0]     ox;
  logic [Y_W-1:0]     oy;
  logic [COLOR_W-1:0] ocolor;

  modport master (output out_valid, ox, oy, ocolor, input out_ready);
  modport slave  (input out_valid, ox, oy, ocolor, output out_ready);
endinterface

// File: rtl/sprite_scanner.sv
// rtl/sprite_scanner.sv - sprite bounding-box walker emitting masked pixel writes
// Optional screen clipping: define SPRITE_SCANNER_CLIP_EN.
module sprite_scanner #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3,
  parameter int SPR_W    = 16,
  parameter int SPR_H    = 21,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [X_W-1:0]     x_in,
  input  logic [Y_W-1:0]     y_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  sprite_scanner_if.master   pix
);
  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);

  if (SPR_W < 1 || SPR_H < 1 || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_param
    $error("sprite_scanner: sizes must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t             state;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [COLOR_W-1:0] color;
  logic               mode_q;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               slot_free;
  logic               in_mask;
  logic [X_W-1:0]     px;
  logic [Y_W-1:0]     py;

  assign slot_free = !pix.out_valid || pix.out_ready;
  assign px        = x0 + X_W'(col);
  assign py        = y0 + Y_W'(row);

`ifdef SPRITE_SCANNER_CLIP_EN
  // Clip on the unwrapped sum so an origin near the edge never wraps onto the screen.
  logic [31:0] x_full, y_full;
  assign x_full  = 32'(x0) + 32'(col);
  assign y_full  = 32'(y0) + 32'(row);
  assign in_mask = (!mode_q || (32'(col) <= 32'(row)))
                   && (x_full < 32'(SCREEN_W)) && (y_full < 32'(SCREEN_H));
`else
  assign in_mask = !mode_q || (32'(col) <= 32'(row));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pix.out_valid <= 1'b0;
      pix.ox        <= '0;
      pix.oy        <= '0;
      pix.ocolor    <= '0;
      x0            <= '0;
      y0            <= '0;
      color         <= '0;
      mode_q        <= 1'b0;
      col           <= '0;
      row           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x0     <= x_in;
            y0     <= y_in;
            color  <= color_in;
            mode_q <= mode;
            col    <= '0;
            row    <= '0;
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (slot_free) begin
            pix.out_valid <= in_mask;
            if (in_mask) begin
              pix.ox     <= px;
              pix.oy     <= py;
              pix.ocolor <= color;
            end
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row   <= '0;
                state <= DRAIN;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (slot_free) begin
            pix.out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_scanner.sv
// tb/tb_sprite_scanner.sv - directed self-checking bench for sprite_scanner
module tb_sprite_scanner;
  localparam int X_W = 9, Y_W = 8, COLOR_W = 3;
  localparam int SPR_W = 16, SPR_H = 21, SCREEN_W = 320, SCREEN_H = 240;

  logic               clk = 1'b0;
  logic               reset, start, mode, busy, done;
  logic [X_W-1:0]     x_in;
  logic [Y_W-1:0]     y_in;
  logic [COLOR_W-1:0] color_in;
  int                 checks = 0, errors = 0;

  sprite_scanner_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) pix ();

  sprite_scanner #(
    .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .SPR_W(SPR_W), .SPR_H(SPR_H),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .color_in(color_in), .mode(mode), .busy(busy), .done(done), .pix(pix)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_scan(input int x0, input int y0, input int c, input int m,
                          input bit bp, input int abort_at, input bit poke, input int exp_n);
    int qx[$], qy[$];
    int n_acc = 0, k = 0, done_k = -1, hx = 0, hy = 0, hc = 0;
    bit stalled = 0, inm;
    for (int r = 0; r < SPR_H; r++) begin
      for (int cc = 0; cc < SPR_W; cc++) begin
        inm = (m == 0) || (cc <= r);
`ifdef SPRITE_SCANNER_CLIP_EN
        if (x0 + cc >= SCREEN_W || y0 + r >= SCREEN_H) inm = 0;
`endif
        if (inm) begin
          qx.push_back((x0 + cc) % (1 << X_W));
          qy.push_back((y0 + r) % (1 << Y_W));
        end
      end
    end
    if (abort_at == 0) chk("model_pixel_count", qx.size(), exp_n);
    x_in = X_W'(x0); y_in = Y_W'(y0); color_in = COLOR_W'(c); mode = m[0];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_after_start", pix.out_valid, 0);
    while (k < 6000) begin
      if (poke && k == 5) begin
        start = 1'b1; x_in = 9'd99; y_in = 8'd77; color_in = 3'd1; mode = ~mode;
      end else begin
        start = 1'b0;
      end
      pix.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (k == 1) chk("first_pixel_latency", pix.out_valid, 1);
      if (stalled) begin
        chk("stall_hold_x", pix.ox, hx);
        chk("stall_hold_y", pix.oy, hy);
        chk("stall_hold_c", pix.ocolor, hc);
        chk("stall_hold_v", pix.out_valid, 1);
      end
      if (done) begin
        done_k = k;
        break;
      end
      chk("busy_during_scan", busy, 1);
      if (pix.out_valid && pix.out_ready) begin
        if (qx.size() == 0) begin
          chk("extra_pixel", 1, 0);
        end else begin
          chk("pixel_x", pix.ox, qx.pop_front());
          chk("pixel_y", pix.oy, qy.pop_front());
          chk("pixel_color", pix.ocolor, c);
        end
        n_acc++;
      end
      stalled = pix.out_valid && !pix.out_ready;
      hx = pix.ox; hy = pix.oy; hc = pix.ocolor;
      tick();
      k++;
      if (abort_at > 0 && n_acc == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", pix.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ox", pix.ox, 0);
        for (int i = 0; i < 4; i++) begin
          tick();
          chk("abort_no_done", done, 0);
          chk("abort_stays_idle", busy, 0);
        end
        return;
      end
    end
    chk("done_seen", (done_k >= 0), 1);
    chk("pixels_remaining", qx.size(), 0);
    chk("pixels_accepted", n_acc, exp_n);
    chk("busy_low_with_done", busy, 0);
    chk("valid_low_with_done", pix.out_valid, 0);
    if (!bp) chk("done_latency", done_k, SPR_W * SPR_H + 1);
    if (poke) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_in_done_busy", busy, 0);
      chk("start_in_done_done", done, 0);
      tick();
      chk("start_in_done_still_idle", busy, 0);
      chk("start_in_done_no_valid", pix.out_valid, 0);
    end else begin
      tick();
      chk("done_one_pulse", done, 0);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; color_in = '0; pix.out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", pix.out_valid, 0);
    chk("reset_ox", pix.ox, 0);
    chk("reset_oy", pix.oy, 0);
    chk("reset_ocolor", pix.ocolor, 0);
    tick();
    chk("idle_valid", pix.out_valid, 0);

    run_scan(10, 20, 5, 0, 1'b0, 0, 1'b1, 336);
    run_scan(0, 0, 6, 1, 1'b0, 0, 1'b0, 216);
    run_scan(10, 20, 5, 0, 1'b1, 0, 1'b0, 336);
`ifdef SPRITE_SCANNER_CLIP_EN
    run_scan(310, 230, 3, 0, 1'b0, 0, 1'b0, 100);
`else
    run_scan(310, 230, 3, 0, 1'b0, 0, 1'b0, 336);
`endif
    run_scan(0, 0, 2, 0, 1'b0, 50, 1'b0, 336);
    run_scan(0, 0, 7, 0, 1'b0, 0, 1'b0, 336);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
